// File: rtl/rec_arb_ser_pkg.sv
// Shared definitions for the record arbiter/serializer.
//   NUM_BYTES : payload bytes per record
//   TAG_W     : width of the record tag
//   rec_t     : packed record. Field a sits above field b, and a[k] occupies
//               bits [TAG_W+8k +: 8].
//   REC_W     : packed width of one record as it appears on req_rec
//   state_t   : serializer FSM states
package rec_arb_ser_pkg;

  localparam int NUM_BYTES = 5;
  localparam int TAG_W     = 5;
  localparam int BYTE_W    = 8;

  typedef struct packed {
    logic [NUM_BYTES-1:0][BYTE_W-1:0] a;
    logic [TAG_W-1:0]                 b;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rec_arb_ser_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i and wraps from NUM_REQ-1 to 0. The first
// requester found with its request bit set wins.
//   req_i       : request vector
//   ptr_i       : index that has the highest priority this cycle
//   gnt_o       : one-hot grant
//   gnt_idx_o   : index of the granted requester
//   gnt_valid_o : at least one request is present
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop. Without the
    // defaults, synthesis would infer a latch on any output the loop does not assign.
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rec_arb_ser.sv
// Record arbiter and byte serializer.
// In IDLE, one requester is granted by round robin and its record is
// captured. In SEND, the payload is emitted one byte per accepted beat.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-requester record valid
//   req_ready  : one-hot accept strobe. It is asserted only in the grant cycle.
//   req_rec    : records packed side by side. Requester i is at [i*REC_W +: REC_W].
//   out_valid  : payload byte valid (the block is in SEND)
//   out_ready  : downstream accepts the current byte
//   out_data   : current payload byte
//   out_tag    : tag of the record in flight
//   out_src    : index of the granted requester
//   out_last   : final byte of the record
//   busy       : a record is held
module rec_arb_ser
  import rec_arb_ser_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_BYTES = rec_arb_ser_pkg::NUM_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*REC_W-1:0]   req_rec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_last,
  output logic                       busy
);

  localparam int SRC_W    = $clog2(NUM_REQ);
  localparam int IDX_W    = $clog2(NUM_BYTES);
  localparam int LAST_IDX = NUM_BYTES - 1;

  rec_t req_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = rec_t'(req_rec[i*REC_W +: REC_W]);
  end

  state_t             state_q, state_d;
  rec_t               rec_q, rec_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               last_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign last_beat = (idx_q == IDX_W'(LAST_IDX));

  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    src_d     = src_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // No grant is made while reset is high, so no requester sees a
        // handshake that the reset would then discard.
        if (gnt_valid && !rst) begin
          req_ready = gnt;
          rec_d     = req_arr[gnt_idx];
          src_d     = gnt_idx;
          idx_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            // idx stays at the last byte, so out_data keeps showing it in IDLE.
            state_d  = ST_IDLE;
            rr_ptr_d = (int'(src_q) == NUM_REQ - 1) ? '0 : src_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments, so every register
    // samples its value from before the clock edge.
    if (rst) begin
      state_q  <= ST_IDLE;
      // NOTE: the record register is cleared on reset because out_data and
      // out_tag are visible in IDLE and must read zero after reset.
      rec_q    <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rec_q    <= rec_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign out_last  = out_valid && last_beat;
  assign out_data  = rec_q.a[idx_q];
  assign out_tag   = rec_q.b;
  assign out_src   = src_q;

endmodule

// File: doc/rec_arb_ser.md
REC_ARB_SER -- requirements
Module: rec_arb_ser

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters, legal range 2..8.
REQ-002 Parameter NUM_BYTES, default 5: bytes per record; SHALL equal the package record payload length.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester record valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept strobe, at most one bit set.
REQ-007 req_rec  input  NUM_REQ x record  per-requester record: payload a[0..4] (8b each) plus tag b (5b).
REQ-008 out_valid  output  1  output byte valid.
REQ-009 out_ready  input  1  downstream accepts byte.
REQ-010 out_data  output  8  current payload byte.
REQ-011 out_tag  output  5  tag of the record being sent.
REQ-012 out_src  output  clog2(NUM_REQ)  index of the granted requester.
REQ-013 out_last  output  1  high on the final byte of a record.
REQ-014 busy  output  1  high while a record is held (state SEND).

Function
REQ-015 FSM states: IDLE, SEND.
REQ-016 IDLE: if any req_valid bit is set, grant one requester by round-robin, starting search at rr_ptr and wrapping at NUM_REQ-1 -> 0.
REQ-017 Grant cycle: req_ready[g]=1 combinationally in IDLE only; req_rec[g] captured into the record register; out_src<=g; byte index<=0; next state SEND.
REQ-018 A requester SHALL NOT see req_ready outside IDLE; req_ready is 0 in SEND.
REQ-019 SEND: out_valid=1; out_data=a[idx]; out_tag=b; out_last=(idx==NUM_BYTES-1).
REQ-020 Beat transfer occurs when out_valid&&out_ready; then idx<=idx+1.
REQ-021 out_ready low: out_data, out_tag, out_src, out_last held stable; no timeout.
REQ-022 Transfer with out_last=1: next state IDLE; rr_ptr<=(g+1) mod NUM_REQ.
REQ-023 Latency: first byte valid 1 cycle after grant. Minimum period per record: NUM_BYTES+1 cycles (1 IDLE grant cycle + NUM_BYTES beats).
REQ-024 In IDLE: out_valid=0, out_last=0, busy=0. out_data, out_tag and out_src hold their last values.
REQ-025 req_valid may deassert at any time before grant with no side effect. Captured data is unaffected by later changes to req_rec.
REQ-026 Simultaneous requests: exactly one grant per IDLE cycle. No requester starves: worst-case wait is NUM_REQ-1 records.
REQ-027 idx width clog2(NUM_BYTES); idx never exceeds NUM_BYTES-1; it is reset to 0 on every grant.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, idx=0, record register=0, out_src=0. Next cycle outputs: out_valid=0, out_last=0, busy=0, out_data=0, out_tag=0, req_ready=0 during the reset cycle.
REQ-029 Reset during SEND aborts the record. No further bytes of it are emitted, and no requester is re-granted until rst is low.

Structure
REQ-030 The record typedef (a: 5 x 8b, b: 5b) and constants NUM_BYTES=5 and TAG_W=5 SHALL live in the shared package. The block imports it.
REQ-031 One sub-module: rr_arbiter (NUM_REQ-wide, combinational grant from request vector and rr_ptr, one-hot plus index outputs). FSM and serializer stay in rec_arb_ser.

Verification
REQ-032 Single request: req 0 with a={11,22,33,44,55}, b=7, out_ready=1 -> out_data 11,22,33,44,55 on 5 consecutive cycles starting 1 cycle after grant; out_tag=7, out_src=0, out_last only on 55.
REQ-033 Both requesting continuously, rr_ptr=0 -> grants alternate 0,1,0,1. Each grant follows the previous last beat by exactly 1 cycle.
REQ-034 Backpressure: out_ready low for 3 cycles on byte 2 -> out_data holds 33 with out_valid=1 for those cycles, then the sequence resumes with no byte lost or duplicated.
REQ-035 Reset mid-record: rst asserted after byte 1 of req 1 -> out_valid=0 and busy=0 the next cycle, rr_ptr=0. A subsequent req 1 restarts from a[0].
REQ-036 Input change after grant: req_rec[0] modified during SEND -> emitted bytes match the values captured at grant.
